// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: ALU op codes, opcode and funct3 constants,
// immediate-format selector and the ID/EX pipeline entry layout.
package rv32_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_JALR = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    alu_op_e         alu_control;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [4:0]      rd;
    logic            reg_write;
    logic [XLEN-1:0] link_pc;
    logic            is_branch;
    logic            is_jump;
    logic [2:0]      br_funct3;
    logic            illegal;
  } issue_entry_t;

endpackage

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction for the I/S/B/U/J instruction formats.
// Only instr[31:7] carries immediate bits, so the opcode is not an input.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:7]     instr,
  input  imm_sel_e        imm_sel,
  output logic [XLEN-1:0] imm
);

  // Pick the immediate layout requested by the decoder; all sign-extend from bit 31.
  always_comb begin
    imm = {{21{instr[31]}}, instr[30:20]};
    case (imm_sel)
      IMM_I: imm = {{21{instr[31]}}, instr[30:20]};
      IMM_S: imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      IMM_B: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{21{instr[31]}}, instr[30:20]};
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes one RV32I instruction into ALU control, operands
// and side-band, then holds it in a single-entry ID/EX register with
// valid/ready flow control and flush.
module alu_issue_stage
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [3:0]      alu_control,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic [XLEN-1:0] link_pc,
  output logic            is_branch,
  output logic            is_jump,
  output logic [2:0]      br_funct3,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] shamt;
  imm_sel_e        imm_sel;
  logic [XLEN-1:0] imm;
  issue_entry_t    dec;
  logic            writes_rd;
  logic            capture;
  logic            valid_d, valid_q;
  issue_entry_t    entry_d, entry_q;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

  // Immediate format depends only on the opcode.
  always_comb begin
    imm_sel = IMM_I;
    case (opcode)
      OPC_STORE:           imm_sel = IMM_S;
      OPC_BRANCH:          imm_sel = IMM_B;
      OPC_LUI, OPC_AUIPC:  imm_sel = IMM_U;
      OPC_JAL:             imm_sel = IMM_J;
      default:             imm_sel = IMM_I;
    endcase
  end

  imm_gen u_imm_gen (
    .instr   (instr[31:7]),
    .imm_sel (imm_sel),
    .imm     (imm)
  );

  // Decode the instruction into the entry that would be captured this cycle.
  always_comb begin
    dec             = '0;
    dec.alu_control = ALU_ADD;
    dec.rd          = instr[11:7];
    writes_rd       = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.operand_a = rs1_data;
        dec.operand_b = rs2_data;
        writes_rd     = 1'b1;
        case (funct3)
          F3_ADD_SUB: dec.alu_control = funct7[5] ? ALU_SUB : ALU_ADD;
          F3_SLL:     dec.alu_control = ALU_SLL;
          F3_SLT:     dec.alu_control = ALU_SLT;
          F3_SLTU:    dec.alu_control = ALU_SLTU;
          F3_XOR:     dec.alu_control = ALU_XOR;
          F3_SRL_SRA: dec.alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
          F3_OR:      dec.alu_control = ALU_OR;
          default:    dec.alu_control = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        dec.operand_a = rs1_data;
        dec.operand_b = imm;
        writes_rd     = 1'b1;
        case (funct3)
          F3_ADD_SUB: dec.alu_control = ALU_ADD;
          F3_SLL: begin
            dec.operand_b   = shamt;
            dec.alu_control = ALU_SLL;
            dec.illegal     = (funct7 != 7'h00);
          end
          F3_SLT:  dec.alu_control = ALU_SLT;
          F3_SLTU: dec.alu_control = ALU_SLTU;
          F3_XOR:  dec.alu_control = ALU_XOR;
          F3_SRL_SRA: begin
            dec.operand_b   = shamt;
            dec.alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
            dec.illegal     = (funct7 != 7'h00) && (funct7 != 7'h20);
          end
          F3_OR:   dec.alu_control = ALU_OR;
          default: dec.alu_control = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        dec.operand_b = imm;
        writes_rd     = 1'b1;
      end
      OPC_AUIPC: begin
        dec.operand_a = pc;
        dec.operand_b = imm;
        writes_rd     = 1'b1;
      end
      OPC_JAL: begin
        dec.operand_a = pc;
        dec.operand_b = imm;
        dec.is_jump   = 1'b1;
        dec.link_pc   = pc + 32'd4;
        writes_rd     = 1'b1;
      end
      OPC_JALR: begin
        dec.operand_a   = rs1_data;
        dec.operand_b   = imm;
        dec.alu_control = ALU_JALR;
        dec.is_jump     = 1'b1;
        dec.link_pc     = pc + 32'd4;
        writes_rd       = 1'b1;
      end
      OPC_LOAD: begin
        dec.operand_a = rs1_data;
        dec.operand_b = imm;
        writes_rd     = 1'b1;
      end
      OPC_STORE: begin
        dec.operand_a = rs1_data;
        dec.operand_b = imm;
      end
      OPC_BRANCH: begin
        dec.operand_a = rs1_data;
        dec.operand_b = rs2_data;
        dec.is_branch = 1'b1;
        dec.br_funct3 = funct3;
        case (funct3)
          F3_BEQ, F3_BNE:   dec.alu_control = ALU_SUB;
          F3_BLT, F3_BGE:   dec.alu_control = ALU_SLT;
          F3_BLTU, F3_BGEU: dec.alu_control = ALU_SLTU;
          default:          dec.illegal     = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal encoding still flows but must have no architectural side effect.
    if (dec.illegal) begin
      dec.alu_control = ALU_ADD;
      dec.is_branch   = 1'b0;
      dec.is_jump     = 1'b0;
      dec.br_funct3   = 3'b000;
      dec.link_pc     = '0;
      writes_rd       = 1'b0;
    end
    dec.reg_write = writes_rd && (dec.rd != 5'd0);
  end

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Next state of the ID/EX register: flush wins, then capture, then consume.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      entry_d = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // ID/EX pipeline register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign out_valid   = valid_q;
  assign operand_a   = entry_q.operand_a;
  assign operand_b   = entry_q.operand_b;
  assign alu_control = entry_q.alu_control;
  assign rd          = entry_q.rd;
  assign reg_write   = entry_q.reg_write;
  assign link_pc     = entry_q.link_pc;
  assign is_branch   = entry_q.is_branch;
  assign is_jump     = entry_q.is_jump;
  assign br_funct3   = entry_q.br_funct3;
  assign illegal     = entry_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: a decode vector table applied
// back-to-back, plus hand-written stall, flush and async-reset sequences.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_control;
  logic [4:0]  rd;
  logic        reg_write;
  logic [31:0] link_pc;
  logic        is_branch;
  logic        is_jump;
  logic [2:0]  br_funct3;
  logic        illegal;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        jmp;
    logic        ill;
    logic [31:0] link;
    logic [2:0]  f3;
    bit          chk_ops;
    bit          chk_rd;
  } vec_t;

  vec_t vecs[$];

  alu_issue_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .pc          (pc),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .alu_control (alu_control),
    .rd          (rd),
    .reg_write   (reg_write),
    .link_pc     (link_pc),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .br_funct3   (br_funct3),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add_vec(string name, logic [31:0] i, logic [31:0] p,
                                  logic [31:0] r1, logic [31:0] r2, logic [3:0] alu,
                                  logic [31:0] a, logic [31:0] b, logic [4:0] d,
                                  logic rw, logic br, logic jmp, logic ill,
                                  logic [31:0] link, logic [2:0] f3,
                                  bit chk_ops, bit chk_rd);
    vec_t v;
    v.name = name; v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
    v.alu = alu; v.a = a; v.b = b; v.rd = d; v.rw = rw; v.br = br;
    v.jmp = jmp; v.ill = ill; v.link = link; v.f3 = f3;
    v.chk_ops = chk_ops; v.chk_rd = chk_rd;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic v, input logic rdy, input logic fl);
    instr     = i;
    pc        = p;
    rs1_data  = r1;
    rs2_data  = r2;
    in_valid  = v;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    //      name      instr          pc          rs1          rs2      alu  A            B            rd rw br jp il link        f3 ops rd
    add_vec("addi",   32'h00510093, 32'h0,      32'd7,       32'd0,   0,   32'd7,       32'd5,       1, 1, 0, 0, 0, 32'h0,      0, 1, 1);
    add_vec("sub",    32'h402081B3, 32'h0,      32'd20,      32'd3,   1,   32'd20,      32'd3,       3, 1, 0, 0, 0, 32'h0,      0, 1, 1);
    add_vec("srai",   32'h40335293, 32'h0,      32'h80000000,32'd0,   9,   32'h80000000,32'd3,       5, 1, 0, 0, 0, 32'h0,      0, 1, 1);
    add_vec("lui",    32'h123453B7, 32'h0,      32'hDEAD,    32'd0,   0,   32'h0,       32'h12345000,7, 1, 0, 0, 0, 32'h0,      0, 1, 1);
    add_vec("jalr",   32'h008100E7, 32'h100,    32'h2000,    32'd0,   10,  32'h2000,    32'd8,       1, 1, 0, 1, 0, 32'h104,    0, 1, 1);
    add_vec("blt",    32'h0020C463, 32'h0,      32'd11,      32'd22,  5,   32'd11,      32'd22,      0, 0, 1, 0, 0, 32'h0,      4, 1, 0);
    add_vec("opc7f",  32'h0000007F, 32'h0,      32'd1,       32'd2,   0,   32'h0,       32'h0,       0, 0, 0, 0, 1, 32'h0,      0, 0, 0);
    add_vec("add_x0", 32'h00208033, 32'h0,      32'd5,       32'd6,   0,   32'd5,       32'd6,       0, 0, 0, 0, 0, 32'h0,      0, 1, 1);
    add_vec("slli_f7",32'h40109093, 32'h0,      32'd1,       32'd0,   0,   32'h0,       32'h0,       0, 0, 0, 0, 1, 32'h0,      0, 0, 0);
    add_vec("sw",     32'hFE20AE23, 32'h0,      32'h1000,    32'd9,   0,   32'h1000,    32'hFFFFFFFC,0, 0, 0, 0, 0, 32'h0,      0, 1, 0);
    add_vec("jal",    32'hFF1FF0EF, 32'h200,    32'd0,       32'd0,   0,   32'h200,     32'hFFFFFFF0,1, 1, 0, 1, 0, 32'h204,    0, 1, 1);
    add_vec("auipc",  32'hFFFFF217, 32'h1000,   32'd0,       32'd0,   0,   32'h1000,    32'hFFFFF000,4, 1, 0, 0, 0, 32'h0,      0, 1, 1);
    add_vec("lw",     32'h00C3A303, 32'h0,      32'h40,      32'd0,   0,   32'h40,      32'd12,      6, 1, 0, 0, 0, 32'h0,      0, 1, 1);
    add_vec("br_f3_3",32'h00003063, 32'h0,      32'd0,       32'd0,   0,   32'h0,       32'h0,       0, 0, 0, 0, 1, 32'h0,      0, 0, 0);
    add_vec("or",     32'h00A4E433, 32'h0,      32'hF0,      32'h0F,  3,   32'hF0,      32'h0F,      8, 1, 0, 0, 0, 32'h0,      0, 1, 1);
    add_vec("sltiu",  32'hFFF13093, 32'h0,      32'd3,       32'd0,   6,   32'd3,       32'hFFFFFFFF,1, 1, 0, 0, 0, 32'h0,      0, 1, 1);

    // Reset state, with and without the reset asserted.
    repeat (2) @(negedge clk);
    checkOutput("rst.out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst.alu_control", 32'(alu_control), 32'h0);
    checkOutput("rst.operand_a", operand_a, 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst.in_ready", 32'(in_ready), 32'h1);
    checkOutput("rst.reg_write", 32'(reg_write), 32'h0);
    checkOutput("rst.link_pc", link_pc, 32'h0);

    // Decode table applied back-to-back with out_ready held high.
    foreach (vecs[k]) begin
      @(negedge clk);
      applyStimulus(vecs[k].instr, vecs[k].pc, vecs[k].rs1, vecs[k].rs2, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checkOutput({vecs[k].name, ".out_valid"}, 32'(out_valid), 32'h1);
      checkOutput({vecs[k].name, ".alu"}, 32'(alu_control), 32'(vecs[k].alu));
      checkOutput({vecs[k].name, ".reg_write"}, 32'(reg_write), 32'(vecs[k].rw));
      checkOutput({vecs[k].name, ".is_branch"}, 32'(is_branch), 32'(vecs[k].br));
      checkOutput({vecs[k].name, ".is_jump"}, 32'(is_jump), 32'(vecs[k].jmp));
      checkOutput({vecs[k].name, ".illegal"}, 32'(illegal), 32'(vecs[k].ill));
      if (vecs[k].chk_ops) begin
        checkOutput({vecs[k].name, ".operand_a"}, operand_a, vecs[k].a);
        checkOutput({vecs[k].name, ".operand_b"}, operand_b, vecs[k].b);
      end
      if (vecs[k].chk_rd) checkOutput({vecs[k].name, ".rd"}, 32'(rd), 32'(vecs[k].rd));
      if (vecs[k].jmp) checkOutput({vecs[k].name, ".link_pc"}, link_pc, vecs[k].link);
      if (vecs[k].br) checkOutput({vecs[k].name, ".br_funct3"}, 32'(br_funct3), 32'(vecs[k].f3));
    end

    // Drain, then stall: capture ADDI, hold out_ready low for three cycles.
    @(negedge clk);
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("drain.out_valid", 32'(out_valid), 32'h0);
    applyStimulus(32'h00510093, 32'h0, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(32'h402081B3, 32'h0, 32'd20, 32'd3, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput("stall.in_ready", 32'(in_ready), 32'h0);
      checkOutput("stall.out_valid", 32'(out_valid), 32'h1);
      checkOutput("stall.operand_a", operand_a, 32'd7);
      checkOutput("stall.alu", 32'(alu_control), 32'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checkOutput("release.in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("release.out_valid", 32'(out_valid), 32'h1);
    checkOutput("release.alu", 32'(alu_control), 32'h1);
    checkOutput("release.operand_a", operand_a, 32'd20);

    // Flush kills a held entry and the same-cycle capture.
    @(negedge clk);
    applyStimulus(32'h123453B7, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("flush.out_valid", 32'(out_valid), 32'h0);
    checkOutput("flush.in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    flush = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_flush.out_valid", 32'(out_valid), 32'h1);
    checkOutput("post_flush.operand_b", operand_b, 32'h12345000);

    // Asynchronous reset mid-transfer, no clock edge in between.
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst.out_valid", 32'(out_valid), 32'h0);
    checkOutput("async_rst.operand_b", operand_b, 32'h0);
    checkOutput("async_rst.in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after_rst.out_valid", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Producer side of the ALU interface: decodes one RV32I instruction per accepted transfer into `alu_control`, `operand_a` and `operand_b`, plus write-back and branch side-band. Registers these into a single-entry ID/EX pipeline register with valid/ready flow control, stall and flush. Sits between the register-file read in Decode and the ALU in Execute.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `instr`  in  32  raw instruction word.
- `pc`  in  32  address of `instr`.
- `rs1_data`, `rs2_data`  in  32 each  register-file read data.
- `flush`  in  1  kill the held entry and any same-cycle capture.
- `out_valid`  out  1  registered entry valid toward Execute.
- `out_ready`  in  1  Execute consumes the entry.
- `operand_a`, `operand_b`  out  32 each  ALU operands.
- `alu_control`  out  4  ALU op code (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, JALR=10).
- `rd`  out  5  destination register.
- `reg_write`  out  1  write-back enable; 0 for `rd`=x0.
- `link_pc`  out  32  `pc`+4 for JAL/JALR.
- `is_branch`  out  1  conditional branch.
- `is_jump`  out  1  JAL/JALR.
- `br_funct3`  out  3  branch condition.
- `illegal`  out  1  unrecognised encoding.

## Operation
- Decode, combinational on inputs:
  - OP: operands `rs1`/`rs2`; `funct3`/`funct7[5]` select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - OP-IMM: operands `rs1`/I-imm. SLLI/SRLI/SRAI use `imm[4:0]` and `funct7[5]`. SLLI with `funct7`≠0, or SRxI with `funct7`∉{0x00,0x20}, is illegal.
  - LUI: `operand_a`=0, `operand_b`=U-imm, ADD.
  - AUIPC: `operand_a`=`pc`, `operand_b`=U-imm, ADD.
  - JAL: `operand_a`=`pc`, `operand_b`=J-imm, ADD; `is_jump`=1.
  - JALR: `operand_a`=`rs1`, `operand_b`=I-imm, JALR op; `is_jump`=1.
  - LOAD/STORE: `operand_a`=`rs1`, `operand_b`=I-/S-imm, ADD. LOAD sets `reg_write`; STORE does not.
  - BRANCH:
    - BEQ/BNE→SUB, BLT/BGE→SLT, BLTU/BGEU→SLTU.
    - Operands are `rs1`/`rs2`; `reg_write`=0; `funct3` 010/011 are illegal.
  - All immediates are sign-extended from `instr[31]`.
- Any other opcode sets `illegal`=1 with ADD, `reg_write`=0, `is_branch`=0, `is_jump`=0. The entry still flows.

## Timing
- Reset: `out_valid`=0 and all registered outputs 0 (`alu_control`=ADD). `in_ready`=1 once `rst_n` deasserts.
- `in_ready` = !`out_valid` || `out_ready` (combinational, no skid buffer).
- Capture when `in_valid` && `in_ready` && !`flush`. Decoded fields appear on the outputs the next cycle: latency 1.
- Held entry is stable while `out_valid` && !`out_ready`.
- `flush` has priority:
  - next `out_valid`=0; any same-cycle capture is dropped.
  - data registers may hold stale values.
- Simultaneous consume and capture (`out_ready`=1, `in_valid`=1) gives back-to-back transfers at full throughput.
- Reset asserted mid-transfer clears `out_valid` immediately (asynchronous).

## Structure
- Shared package `rv32_pkg`: `alu_op_e` enum (the 11 codes above), opcode constants, `funct3` constants.
- Sub-module `imm_gen`: combinational I/S/B/U/J immediate extraction.
- Top module: decode logic plus the pipeline register.

## Test plan
- ADDI x1,x2,5 (0x00510093), `rs1_data`=7 → next cycle `alu_control`=0, A=7, B=5, `rd`=1, `reg_write`=1.
- SUB x3,x1,x2 (0x402081B3) → `alu_control`=1; SRAI x5,x6,3 (0x40335293) → `alu_control`=9, B=3.
- LUI x7,0x12345 (0x123453B7) → A=0, B=0x12345000, ADD. JALR with `pc`=0x100 → `alu_control`=10, `link_pc`=0x104.
- BLT → SLT, `is_branch`=1, `reg_write`=0. Opcode 0x7F → `illegal`=1, `reg_write`=0.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and outputs stable; release → next instruction captured in the same cycle.
- Assert `flush` with `in_valid`=1 → next cycle `out_valid`=0. Drop `rst_n` mid-stream → `out_valid`=0 with no clock edge.
